// File: rtl/msp_spi_slave_nlane.sv
// Oversampled N-lane MSP SPI command/response slave in the fabric clock domain.
// Define MSP_SPI_TIMEOUT_EN to add the CMD/RESP inactivity timeout.
module msp_spi_slave_nlane #(
    parameter int LANES          = 1,
    parameter int CMD_W          = 64,
    parameter int RESP_W         = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic [LANES-1:0]  spi_din,
    output logic [LANES-1:0]  spi_dout,
    output logic              spi_doe,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [CMD_W-1:0]  cmd_data,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [RESP_W-1:0] resp_data,
    output logic              busy,
    output logic              overrun
);
    localparam int CMD_BEATS  = CMD_W / LANES;
    localparam int RESP_BEATS = RESP_W / LANES;
    localparam int MAX_BEATS  = (CMD_BEATS > RESP_BEATS) ? CMD_BEATS : RESP_BEATS;
    localparam int CNT_W      = $clog2(MAX_BEATS) + 1;

    if ((LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) ||
        (CMD_W % LANES != 0) || (RESP_W % LANES != 0) ||
        (SYNC_STAGES < 2) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
        $error("msp_spi_slave_nlane: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, CMD, CMD_HOLD, RESP_WAIT, RESP} state_t;

    state_t                            state_q;
    logic [SYNC_STAGES-1:0]            sclk_q;
    logic [SYNC_STAGES-1:0][LANES-1:0] din_q;
    logic                              sclk_prev_q;
    logic [CMD_W-1:0]                  cmd_sh_q, cmd_sh_d;
    logic [CMD_W-1:0]                  cmd_data_q;
    logic [RESP_W-1:0]                 resp_sh_q;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              cmd_valid_q;
    logic                              doe_q;
    logic                              overrun_q;
    logic                              rise, fall, timeout;
    logic [LANES-1:0]                  din_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= '0;
            din_q       <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
            din_q       <= {din_q[SYNC_STAGES-2:0], spi_din};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign rise  = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign fall  = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign din_s = din_q[SYNC_STAGES-1];

    // A command always starts from an empty register, so nothing survives an abort
    assign cmd_sh_d = (state_q == IDLE) ? CMD_W'(din_s)
                                        : ((cmd_sh_q << LANES) | CMD_W'(din_s));
    assign cnt_d    = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;

`ifdef MSP_SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            active, to_hit;

    assign active  = (state_q == CMD) || (state_q == RESP);
    assign to_hit  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
    assign timeout = active && to_hit;

    // Held clear outside CMD/RESP so a long app wait cannot trip it on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt_q <= '0;
        else if (rise || fall || !active)
            to_cnt_q <= '0;
        else if (!to_hit)
            to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_sh_q    <= '0;
            cmd_data_q  <= '0;
            resp_sh_q   <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            doe_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, CMD: begin
                    if (rise) begin
                        if (cnt_d == CNT_W'(CMD_BEATS)) begin
                            cmd_data_q  <= cmd_sh_d;
                            cmd_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= CMD_HOLD;
                        end else begin
                            cmd_sh_q <= cmd_sh_d;
                            cnt_q    <= cnt_d;
                            state_q  <= CMD;
                        end
                    end else if (timeout) begin
                        cmd_sh_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                CMD_HOLD: begin
                    if (rise)
                        overrun_q <= 1'b1;
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    if (rise)
                        overrun_q <= 1'b1;
                    if (resp_valid) begin
                        resp_sh_q <= resp_data;
                        doe_q     <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (rise) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (fall && cnt_q == CNT_W'(RESP_BEATS)) begin
                        resp_sh_q <= '0;
                        doe_q     <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (fall && cnt_q != '0) begin
                        resp_sh_q <= resp_sh_q << LANES;
                    end else if (timeout) begin
                        resp_sh_q <= '0;
                        doe_q     <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_dout   = resp_sh_q[RESP_W-1 -: LANES];
    assign spi_doe    = doe_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_data   = cmd_data_q;
    assign resp_ready = (state_q == RESP_WAIT);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_msp_spi_slave_nlane.sv
// Directed + randomized bench for msp_spi_slave_nlane: one 1-lane and one 4-lane instance.
// Timeout checks follow MSP_SPI_TIMEOUT_EN.
module tb_msp_spi_slave_nlane;
    logic        clk = 1'b0;
    logic        rst;
    logic        sclk1, sclk4;
    logic [0:0]  din1, dout1;
    logic [3:0]  din4, dout4;
    logic        doe1, doe4, cv1, cv4, rr1, rr4, busy1, busy4, ovr1, ovr4;
    logic [63:0] cd1, cd4;
    logic        cmd_ready, resp_valid;
    logic [63:0] resp_data;
    logic        sel4;

    int ntests = 0;
    int nfail  = 0;
    int vcyc1  = 0;
    int vcyc4  = 0;
    logic [63:0] cap1 = '0;
    logic [63:0] cap4 = '0;

    always #5 clk = ~clk;

    msp_spi_slave_nlane #(
        .LANES(1), .CMD_W(64), .RESP_W(64), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
    ) u1 (
        .clk(clk), .rst(rst), .spi_clk(sclk1), .spi_din(din1),
        .spi_dout(dout1), .spi_doe(doe1), .cmd_valid(cv1), .cmd_ready(cmd_ready),
        .cmd_data(cd1), .resp_valid(resp_valid), .resp_ready(rr1),
        .resp_data(resp_data), .busy(busy1), .overrun(ovr1)
    );

    msp_spi_slave_nlane #(
        .LANES(4), .CMD_W(64), .RESP_W(64), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
    ) u4 (
        .clk(clk), .rst(rst), .spi_clk(sclk4), .spi_din(din4),
        .spi_dout(dout4), .spi_doe(doe4), .cmd_valid(cv4), .cmd_ready(cmd_ready),
        .cmd_data(cd4), .resp_valid(resp_valid), .resp_ready(rr4),
        .resp_data(resp_data), .busy(busy4), .overrun(ovr4)
    );

    always @(posedge clk) begin
        if (cv1) vcyc1 <= vcyc1 + 1;
        if (cv1 && cmd_ready) cap1 <= cd1;
        if (cv4) vcyc4 <= vcyc4 + 1;
        if (cv4 && cmd_ready) cap4 <= cd4;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SPI clock period at clk/8; q is what the MSP would sample on the rise
    task automatic beat(input logic [3:0] d, output logic [3:0] q);
        if (sel4) din4 = d; else din1 = d[0];
        tick(4);
        q = sel4 ? dout4 : {3'b000, dout1};
        if (sel4) sclk4 = 1'b1; else sclk1 = 1'b1;
        tick(4);
        if (sel4) sclk4 = 1'b0; else sclk1 = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int nbeats);
        int lanes = sel4 ? 4 : 1;
        logic [63:0] t;
        logic [3:0]  q;
        for (int i = 0; i < nbeats; i++) begin
            t = v >> (64 - lanes * (i + 1));
            beat(t[3:0] & (sel4 ? 4'hF : 4'h1), q);
        end
    endtask

    task automatic send_cmd(input logic [63:0] v);
        send_bits(v, sel4 ? 16 : 64);
    endtask

    task automatic give_resp(input logic [63:0] v);
        int n = 0;
        while (!(sel4 ? rr4 : rr1) && n < 100) begin
            tick(1);
            n++;
        end
        chk("resp_ready_seen", sel4 ? rr4 : rr1, 1'b1);
        resp_data  = v;
        resp_valid = 1'b1;
        tick(1);
        resp_valid = 1'b0;
    endtask

    task automatic recv(output logic [63:0] got, output logic allbusy);
        int lanes = sel4 ? 4 : 1;
        logic [3:0] q;
        got     = '0;
        allbusy = 1'b1;
        for (int i = 0; i < 64 / lanes; i++) begin
            beat(4'h0, q);
            got     = (got << lanes) | 64'(q);
            allbusy = allbusy & (sel4 ? busy4 : busy1);
        end
    endtask

    initial begin
        logic [63:0] c, r, got;
        logic        ab, stable;
        int          base, n;

        rst = 1'b1; sclk1 = 1'b0; sclk4 = 1'b0; din1 = '0; din4 = '0;
        cmd_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; sel4 = 1'b0;
        tick(3);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_doe1", doe1, 1'b0);
        chk("rst_cv1", cv1, 1'b0);
        chk("rst_cd1", cd1, 64'h0);
        chk("rst_rr1", rr1, 1'b0);
        chk("rst_dout1", dout1, 1'b0);
        chk("rst_ovr1", ovr1, 1'b0);
        rst = 1'b0;
        tick(2);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_cd4", cd4, 64'h0);
        chk("rst_dout4", dout4, 4'h0);

        // single lane command with cmd_ready held high
        sel4 = 1'b0; cmd_ready = 1'b1; base = vcyc1;
        send_cmd(64'hA5A5_0000_DEAD_BEEF);
        tick(6);
        chk("l1_pulses", vcyc1 - base, 1);
        chk("l1_cmd", cap1, 64'hA5A5_0000_DEAD_BEEF);
        chk("l1_busy_wait", busy1, 1'b1);
        chk("l1_rr", rr1, 1'b1);
        cmd_ready = 1'b0;
        r = {$urandom, $urandom};
        give_resp(r);
        chk("l1_doe_on", doe1, 1'b1);
        recv(got, ab);
        chk("l1_busy_resp", ab, 1'b1);
        tick(6);
        chk("l1_resp", got, r);
        chk("l1_busy_end", busy1, 1'b0);
        chk("l1_doe_off", doe1, 1'b0);

        // four lanes: backpressure, overrun, fixed response pattern
        sel4 = 1'b1; cmd_ready = 1'b0;
        c = {$urandom, $urandom};
        send_cmd(c);
        tick(6);
        chk("bp_valid", cv4, 1'b1);
        chk("bp_data", cd4, c);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (!(cv4 === 1'b1 && cd4 === c && busy4 === 1'b1 && rr4 === 1'b0))
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_ovr", ovr4, 1'b0);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(2);
        chk("bp_valid_drop", cv4, 1'b0);
        chk("bp_cap", cap4, c);
        chk("bp_rr", rr4, 1'b1);
        send_bits({$urandom, $urandom}, 3);
        tick(6);
        chk("ovr_set", ovr4, 1'b1);
        chk("ovr_state", rr4, 1'b1);
        give_resp(64'h0123_4567_89AB_CDEF);
        chk("l4_doe_on", doe4, 1'b1);
        recv(got, ab);
        chk("l4_busy_resp", ab, 1'b1);
        tick(6);
        chk("l4_nibbles", got, 64'h0123_4567_89AB_CDEF);
        chk("l4_doe_off", doe4, 1'b0);
        chk("ovr_sticky", ovr4, 1'b1);

        // randomized round trips on both instances
        cmd_ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            sel4 = it[0];
            base = sel4 ? vcyc4 : vcyc1;
            c = {$urandom, $urandom};
            r = {$urandom, $urandom};
            send_cmd(c);
            tick(6);
            chk("rnd_cmd", sel4 ? cap4 : cap1, c);
            chk("rnd_pulses", (sel4 ? vcyc4 : vcyc1) - base, 1);
            give_resp(r);
            recv(got, ab);
            tick(6);
            chk("rnd_resp", got, r);
            chk("rnd_idle", sel4 ? busy4 : busy1, 1'b0);
        end

        // reset in the middle of a command
        sel4 = 1'b0;
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_ovr4", ovr4, 1'b0);
        rst = 1'b0;
        tick(2);
        base = vcyc1;
        send_cmd(64'h1);
        tick(6);
        chk("mid_rst_cmd", cap1, 64'h1);
        chk("mid_rst_pulses", vcyc1 - base, 1);
        r = {$urandom, $urandom};
        give_resp(r);
        recv(got, ab);
        tick(6);
        chk("mid_rst_resp", got, r);

`ifdef MSP_SPI_TIMEOUT_EN
        send_bits({$urandom, $urandom}, 10);
        n = 0;
        while (busy1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("to_idle", busy1, 1'b0);
        chk("to_window", (n >= 60 && n <= 70), 1'b1);
        c = {$urandom, $urandom};
        send_cmd(c);
        tick(6);
        chk("to_next_cmd", cap1, c);
        give_resp(r);
        recv(got, ab);
        tick(6);
        chk("to_next_resp", got, r);
`else
        send_bits({$urandom, $urandom}, 10);
        tick(200);
        chk("no_to_busy", busy1, 1'b1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("no_to_rst", busy1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/msp_spi_slave_nlane.md
Name: msp_spi_slave_nlane

Overview:
- Parametrised successor to the single-lane MSP SPI command port.
- Runs entirely in the fabric clock domain and oversamples the MSP SPI clock and data lanes.
- Deserialises a command of CMD_W bits across LANES data lines, hands it to the app over a valid/ready handshake, then serialises a RESP_W-bit response back on the same lanes.
- Adds an optional inactivity timeout that returns the port to idle, for sim/host resynchronisation.

Parameters:
- LANES, 1, number of bidirectional SPI data lanes; legal values 1, 2, 4, 8.
- CMD_W, 64, command width in bits; must be a multiple of LANES.
- RESP_W, 64, response width in bits; must be a multiple of LANES.
- SYNC_STAGES, 2, synchroniser flops on spi_clk and spi_din; minimum 2.
- TIMEOUT_CYCLES, 4096, clk cycles without a spi_clk edge before the timeout fires; used only with the optional feature.

Ports:
- clk  in  1  fabric clock; must be at least 4x the spi_clk frequency.
- rst  in  1  asynchronous reset, active-high.
- spi_clk  in  1  raw MSP SPI clock; idle low.
- spi_din  in  LANES  raw SPI data lanes from the MSP.
- spi_dout  out  LANES  data driven to the MSP.
- spi_doe  out  1  output enable for all lanes.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  app accepts the command.
- cmd_data  out  CMD_W  received command, MSB first.
- resp_valid  in  1  app offers a response.
- resp_ready  out  1  response accepted.
- resp_data  in  RESP_W  response to send.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; cleared only by rst.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - State is IDLE.
  - spi_dout=0, spi_doe=0, cmd_valid=0, cmd_data=0, resp_ready=0, busy=0, overrun=0.
  - All synchronisers and counters are cleared.
  - Reset asserted mid-transfer aborts the transfer and discards partial bits.
- Edge detection:
  - spi_clk and spi_din pass through SYNC_STAGES flops each.
  - A rise/fall pulse is one clk wide, SYNC_STAGES+1 cycles after the pin edge.
  - Data is captured from the synchronised spi_din in the same cycle as the rise pulse.
- Bit order:
  - MSB first.
  - Each rise shifts in LANES bits; spi_din[LANES-1] carries the highest bit of the group.
  - The edge counter is ceil(log2(max(CMD_W,RESP_W)/LANES))+1 bits wide.
- IDLE:
  - The first rise captures the first group, counter=1, go to CMD.
  - Falls in IDLE are ignored.
- CMD:
  - Each rise shifts in one group.
  - When counter reaches CMD_W/LANES: cmd_data updated, cmd_valid=1 the next cycle, go to CMD_HOLD.
- CMD_HOLD:
  - cmd_valid and cmd_data are held stable until a cycle with cmd_ready=1; then cmd_valid=0 the next cycle, go to RESP_WAIT.
  - The first cycle of cmd_valid may coincide with cmd_ready; a 1-cycle handshake is legal.
- RESP_WAIT:
  - resp_ready=1 combinationally while in this state.
  - On a cycle with resp_valid=1: resp_data is loaded into the shift register and the state moves to RESP.
- RESP:
  - spi_doe=1 on entry.
  - spi_dout drives the top LANES bits; it shifts on each fall after the first, so the first group is valid before the MSP's first rise.
  - The counter counts rises.
  - After RESP_W/LANES rises, on the next fall: spi_doe=0 and go to IDLE.
- Overrun:
  - Any rise in CMD_HOLD or RESP_WAIT sets overrun=1.
  - That rise is otherwise ignored; the state is unchanged.
- Simultaneous events: a rise and fall pulse cannot occur in the same cycle given the clock ratio. If they do, the rise takes priority.

Optional Feature:
- Macro: MSP_SPI_TIMEOUT_EN.
- Defined:
  - A free counter clears on every spi_clk edge and on entry to IDLE.
  - In CMD or RESP, reaching TIMEOUT_CYCLES forces IDLE within 1 cycle: spi_doe=0, partial data discarded, cmd_valid unaffected.
  - CMD_HOLD and RESP_WAIT never time out.
- Undefined: no counter is synthesised, and CMD/RESP wait indefinitely for edges.

Test Plan:
- LANES=1, CMD_W=64:
  - Stimulus: clock in 0xA5A5_0000_DEAD_BEEF at clk/8, hold cmd_ready=1.
  - Response: cmd_valid pulses once with cmd_data=0xA5A5_0000_DEAD_BEEF; busy stays 1 until the response ends.
- LANES=4, RESP_W=64:
  - Stimulus: resp_data=0x0123_4567_89AB_CDEF, then 16 spi_clk pulses.
  - Response: sampled nibbles on the rises are 0,1,2,...,F in order; spi_doe drops after the 16th fall.
- Backpressure:
  - Stimulus: hold cmd_ready=0 for 50 cycles after a full command.
  - Response: cmd_valid and cmd_data stay constant; state stays CMD_HOLD; overrun=0.
- Overrun:
  - Stimulus: issue 3 spi_clk rises during RESP_WAIT.
  - Response: overrun=1 and stays set; the response sent afterwards is still intact.
- Reset mid-CMD:
  - Stimulus: assert rst after 20 of 64 bits, then send a fresh command 0x1.
  - Response: cmd_data=0x1 with no residue from the aborted transfer.
- Timeout (MSP_SPI_TIMEOUT_EN defined, TIMEOUT_CYCLES=64):
  - Stimulus: stop spi_clk after 10 bits.
  - Response: busy=0 by cycle 65; the next full command is received correctly.
